// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the PWM audio link.
//   dec_state_e : decoder state (idle, seeking first edge, high phase, low phase)
//   PWM_FRAME   : frame length in clocks for the default 8-bit sample width
package pwm_pkg;

    localparam int unsigned PWM_FRAME = 256;

    typedef enum logic [1:0] {
        StIdle,
        StSeek,
        StHigh,
        StLow
    } dec_state_e;

endpackage

// File: rtl/pwm_sync_filter.sv
// pwm_sync_filter: brings the asynchronous PWM stream into the clk domain,
// optionally removes single-cycle pulses, and detects edges on the result.
// Build option: define PWM_DEC_GLITCH_FILTER_EN to insert a 3-sample majority
// filter after the synchronizer (adds one cycle of latency).
// Ports:
//   clk     in   system clock
//   nrst    in   asynchronous active-low reset
//   pwm_i   in   raw PWM input, asynchronous to clk
//   p_o     out  cleaned PWM level used by the decoder
//   rise_o  out  p_o went 0 -> 1 this cycle
//   fall_o  out  p_o went 1 -> 0 this cycle
module pwm_sync_filter #(
    parameter int unsigned SYNC_STAGES = 2  // minimum 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic pwm_i,
    output logic p_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   p;
    logic                   p_prev_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PWM_DEC_GLITCH_FILTER_EN
    // Two previous synchronized samples; majority of these plus the current one.
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hist_q <= '0;
        end else begin
            hist_q <= {hist_q[0], sync_out};
        end
    end

    assign p = (sync_out & hist_q[0]) | (sync_out & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign p = sync_out;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            p_prev_q <= 1'b0;
        end else begin
            p_prev_q <= p;
        end
    end

    assign p_o    = p;
    assign rise_o = p & ~p_prev_q;
    assign fall_o = ~p & p_prev_q;

endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder: recovers a WIDTH-bit sample from a PWM stream with a fixed
// 2**WIDTH-clock frame by counting the high time between rising edges.
// Build option: PWM_DEC_GLITCH_FILTER_EN (see pwm_sync_filter) enables a
// majority filter on the input.
// Ports:
//   clk             in   system clock
//   nrst            in   asynchronous active-low reset
//   enable          in   decoder run; low forces idle and drops lock
//   pwm_i           in   PWM stream, asynchronous to clk
//   sample_o        out  last recovered sample, held between updates
//   sample_valid_o  out  one-cycle strobe when sample_o updates
//   locked_o        out  frame boundary seen and decoder tracking
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             enable,
    input  logic             pwm_i,
    output logic [WIDTH-1:0] sample_o,
    output logic             sample_valid_o,
    output logic             locked_o
);

    localparam logic [WIDTH:0] FrameLen = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] CntOne   = {{WIDTH{1'b0}}, 1'b1};

    logic p;
    logic rise;
    logic fall;

    dec_state_e       state_q, state_d;
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH:0]   per_q, per_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             timeout;
    logic             emit;

    pwm_sync_filter #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_filter (
        .clk   (clk),
        .nrst  (nrst),
        .pwm_i (pwm_i),
        .p_o   (p),
        .rise_o(rise),
        .fall_o(fall)
    );

    // A full frame has elapsed with no closing rise.
    assign timeout = (per_q == FrameLen);

    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH:0] v);
        return v[WIDTH] ? {WIDTH{1'b1}} : v[WIDTH-1:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        per_d    = per_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        locked_d = locked_q;
        emit     = 1'b0;

        if (!enable) begin
            state_d  = StIdle;
            hi_d     = '0;
            per_d    = '0;
            locked_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StSeek;
                    hi_d    = '0;
                    per_d   = '0;
                end
                StSeek: begin
                    if (rise) begin
                        state_d = StHigh;
                        hi_d    = CntOne;
                        per_d   = CntOne;
                    end else if (timeout) begin
                        // The timeout cycle itself opens the next frame.
                        per_d = CntOne;
                        if (!p) begin
                            emit    = 1'b1;
                            state_d = StLow;
                            hi_d    = '0;
                        end
                    end else begin
                        per_d = per_q + 1'b1;
                    end
                end
                StHigh: begin
                    if (timeout) begin
                        emit    = 1'b1;
                        per_d   = CntOne;
                        hi_d    = {{WIDTH{1'b0}}, p};
                        state_d = p ? StHigh : StLow;
                    end else if (fall) begin
                        state_d = StLow;
                        per_d   = per_q + 1'b1;
                    end else begin
                        hi_d  = hi_q + 1'b1;
                        per_d = per_q + 1'b1;
                    end
                end
                StLow: begin
                    if (rise) begin
                        emit    = 1'b1;
                        state_d = StHigh;
                        hi_d    = CntOne;
                        per_d   = CntOne;
                    end else if (timeout) begin
                        emit  = 1'b1;
                        hi_d  = '0;
                        per_d = CntOne;
                    end else begin
                        per_d = per_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        if (emit) begin
            sample_d = saturate(hi_q);
            valid_d  = 1'b1;
            locked_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= StIdle;
            hi_q     <= '0;
            per_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            per_q    <= per_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
        end
    end

    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign locked_o       = locked_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: self-checking bench for pwm_decoder. A timestamp/history
// model predicts every output each cycle; literal checks pin key scenarios.
module tb_pwm_decoder;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
    localparam int FRAME = 256;
    localparam int HN    = 2048;

    logic             clk    = 1'b0;
    logic             nrst   = 1'b0;
    logic             enable = 1'b0;
    logic             pwm_i  = 1'b0;
    logic [WIDTH-1:0] sample_o;
    logic             sample_valid_o;
    logic             locked_o;

    pwm_decoder #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .enable        (enable),
        .pwm_i         (pwm_i),
        .sample_o      (sample_o),
        .sample_valid_o(sample_valid_o),
        .locked_o      (locked_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // pw_h[k]: pwm_i as sampled at edge k since reset release.
    bit pw_h [HN];
    int e_n;
    int mode;        // 0 idle, 1 seeking first rise, 2 tracking frames
    int fs;          // edge index at which the current frame started
    bit m_valid;
    int m_sample;
    bit m_locked;
    int me;
    bit mp;
    bit mrise;

    function automatic bit pw_at(int k);
        return (k < 0) ? 1'b0 : pw_h[k % HN];
    endfunction

    function automatic bit s_at(int k);
        return pw_at(k - SYNC);
    endfunction

    function automatic bit p_at(int k);
`ifdef PWM_DEC_GLITCH_FILTER_EN
        int n;
        n = int'(s_at(k)) + int'(s_at(k - 1)) + int'(s_at(k - 2));
        return n >= 2;
`else
        return s_at(k);
`endif
    endfunction

    function automatic int hi_sum(int from, int to);
        int s;
        s = 0;
        for (int k = from; k < to; k++) s += int'(p_at(k));
        return s;
    endfunction

    task automatic m_emit(input int v);
        m_valid  = 1'b1;
        m_sample = (v > FRAME - 1) ? FRAME - 1 : v;
        m_locked = 1'b1;
    endtask

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            e_n      = 0;
            mode     = 0;
            fs       = 0;
            m_valid  = 1'b0;
            m_sample = 0;
            m_locked = 1'b0;
        end else begin
            me             = e_n;
            pw_h[me % HN]  = pwm_i;
            mp             = p_at(me);
            mrise          = mp && !p_at(me - 1);
            m_valid        = 1'b0;
            if (!enable) begin
                mode     = 0;
                m_locked = 1'b0;
            end else if (mode == 0) begin
                mode = 1;
                fs   = me + 1;
            end else if (mode == 1) begin
                if (mrise) begin
                    mode = 2;
                    fs   = me;
                end else if (me - fs == FRAME) begin
                    fs = me;
                    if (!mp) begin
                        m_emit(0);
                        mode = 2;
                    end
                end
            end else begin
                if (mrise || (me - fs == FRAME)) begin
                    m_emit(hi_sum(fs, me));
                    fs = me;
                end
            end
            e_n = me + 1;
        end
    end

    // ---------------- compare + monitors ----------------
    int cyc           = 0;
    int n_valid       = 0;
    int last_vcyc     = 0;
    int last_interval = 0;
    bit cap_arm       = 1'b0;
    int cap_val       = -1;
    bit win_en        = 1'b0;
    bit saw_non100    = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (nrst) begin
            check("valid", int'(sample_valid_o), int'(m_valid));
            check("sample", int'(sample_o), m_sample);
            check("locked", int'(locked_o), int'(m_locked));
            if (sample_valid_o) begin
                n_valid++;
                last_interval = cyc - last_vcyc;
                last_vcyc     = cyc;
                if (cap_arm) begin
                    cap_val = int'(sample_o);
                    cap_arm = 1'b0;
                end
                if (win_en && sample_o != 8'd100) saw_non100 = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pwm_frames(input int duty, input int n);
        for (int f = 0; f < n; f++) begin
            for (int i = 0; i < FRAME; i++) begin
                tick();
                pwm_i = (i < duty);
            end
        end
    endtask

    int vmark;
    int duty;
    int drop;
    int run;
    int left;

    initial begin
        repeat (3) tick();
        check("rst_sample", int'(sample_o), 0);
        check("rst_valid", int'(sample_valid_o), 0);
        check("rst_locked", int'(locked_o), 0);
        nrst = 1'b1;
        tick();
        enable = 1'b1;

        // Loopback at mid-scale.
        pwm_frames(128, 4);
        check("lb128_sample", int'(sample_o), 128);
        check("lb128_locked", int'(locked_o), 1);
        check("lb128_period", last_interval, 256);

        // Stepping 0 -> 1 -> 254 -> 255.
        pwm_frames(0, 3);
        check("zero_sample", int'(sample_o), 0);
        check("zero_period", last_interval, 256);
        pwm_frames(1, 3);
        check("one_sample", int'(sample_o), 1);
        pwm_frames(254, 3);
        check("s254_sample", int'(sample_o), 254);
        pwm_frames(255, 3);
        check("s255_sample", int'(sample_o), 255);
        check("s255_period", last_interval, 256);

        // Constant high.
        pwm_i = 1'b1;
        repeat (1000) tick();
        check("hold_hi_sample", int'(sample_o), 255);
        check("hold_hi_period", last_interval, 256);

        // Enable dropped mid-frame.
        pwm_frames(200, 3);
        check("pre_drop_sample", int'(sample_o), 200);
        vmark = n_valid;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            pwm_i = (i < 200);
            if (i == 100) begin
                enable = 1'b0;
                vmark  = n_valid;
            end
        end
        pwm_frames(200, 1);
        check("drop_no_strobe", n_valid, vmark);
        check("drop_hold", int'(sample_o), 200);
        check("drop_unlocked", int'(locked_o), 0);
        enable  = 1'b1;
        cap_arm = 1'b1;
        pwm_frames(200, 3);
        check("reen_first", cap_val, 200);
        check("reen_locked", int'(locked_o), 1);

        // Reset asserted during the high phase, released during the low phase.
        for (int i = 0; i < FRAME; i++) begin
            tick();
            pwm_i = (i < 200);
            if (i == 50) begin
                #2;
                nrst = 1'b0;
                #1;
                check("arst_sample", int'(sample_o), 0);
                check("arst_valid", int'(sample_valid_o), 0);
                check("arst_locked", int'(locked_o), 0);
            end
            if (i == 220) nrst = 1'b1;
        end
        vmark   = n_valid;
        cap_val = -1;
        cap_arm = 1'b1;
        pwm_frames(200, 1);
        check("arst_first_rise", n_valid, vmark);
        pwm_frames(200, 1);
        check("arst_second_rise", n_valid, vmark + 1);
        check("arst_value", cap_val, 200);

        // Single-cycle pulse in the low phase of a sample-100 frame.
        pwm_frames(100, 2);
        win_en     = 1'b1;
        saw_non100 = 1'b0;
        vmark      = n_valid;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            pwm_i = (i < 100) || (i == 180);
        end
        pwm_frames(100, 2);
        win_en = 1'b0;
`ifdef PWM_DEC_GLITCH_FILTER_EN
        check("glitch_filtered", int'(saw_non100), 0);
        check("glitch_count", n_valid - vmark, 3);
`else
        check("glitch_spurious", int'(saw_non100), 1);
        check("glitch_count", n_valid - vmark, 4);
`endif

        // Random frames with occasional glitches and enable drops.
        for (int f = 0; f < 30; f++) begin
            duty = $urandom_range(0, 255);
            drop = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 200)) : -100;
            for (int i = 0; i < FRAME; i++) begin
                tick();
                pwm_i = (i < duty);
                if ($urandom_range(0, 199) == 0) pwm_i = ~pwm_i;
                if (i == drop) enable = 1'b0;
                if (i == drop + 20) enable = 1'b1;
            end
        end

        // Random run-length noise.
        left = 1500;
        while (left > 0) begin
            run   = $urandom_range(1, 300);
            pwm_i = ~pwm_i;
            for (int k = 0; k < run; k++) tick();
            left -= run;
        end

        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
